dec_scan_sequencer: RTL and testbench

DEC_SCAN_SEQUENCER -- requirements
Module: dec_scan_sequencer

---
 rtl/dec_scan_sequencer.sv | 130 +++++++++++++
 tb/tb_dec_scan_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_scan_sequencer.sv
// Channel scan sequencer for a downstream 4-to-16 decoder: walks the enabled
// channels of a captured mask, holding each for a programmable dwell.
module dec_scan_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [15:0]        mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
    output logic [3:0]         a,
    output logic               en,
    output logic               busy,
    output logic               done
);

    localparam int unsigned NCH = 16;
    localparam int unsigned AW  = 4;

    typedef enum logic [1:0] {IDLE, DWELL, FINISH} state_t;

    state_t             state;
    logic [NCH-1:0]     cap_mask;
    logic [DWELL_W-1:0] cap_dwell;
    logic               cap_cont;
    logic [DWELL_W-1:0] cnt;

    logic [NCH-1:0]     above_mask;
    logic               has_next;
    logic [AW-1:0]      next_idx;
    logic [AW-1:0]      wrap_idx;
    logic [AW-1:0]      start_idx;
    logic [DWELL_W-1:0] dwell_eff;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [AW-1:0] lowest_idx(input logic [NCH-1:0] m);
        logic [AW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = AW'(i);
        end
        return r;
    endfunction

    // Next-channel search: captured-mask bits strictly above the current index.
    always_comb begin
        above_mask = cap_mask & ~((NCH'(2) << a) - NCH'(1));
        has_next   = |above_mask;
        next_idx   = lowest_idx(above_mask);
        wrap_idx   = lowest_idx(cap_mask);
        start_idx  = lowest_idx(mask);
        dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
    end

    // cnt counts 1..cap_dwell for the current channel, so it never exceeds the
    // captured dwell and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_mask  <= '0;
            cap_dwell <= '0;
            cap_cont  <= 1'b0;
            cnt       <= '0;
            a         <= '0;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        cap_mask  <= mask;
                        cap_dwell <= dwell_eff;
                        cap_cont  <= continuous;
                        if (mask != '0) begin
                            state <= DWELL;
                            a     <= start_idx;
                            en    <= 1'b1;
                            busy  <= 1'b1;
                            cnt   <= DWELL_W'(1);
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                DWELL: begin
                    if (stop) begin
                        state <= IDLE;
                        a     <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt >= cap_dwell) begin
                        if (has_next) begin
                            a   <= next_idx;
                            cnt <= DWELL_W'(1);
                        end else if (cap_cont) begin
                            a   <= wrap_idx;
                            cnt <= DWELL_W'(1);
                        end else begin
                            state <= FINISH;
                            a     <= '0;
                            en    <= 1'b0;
                            busy  <= 1'b0;
                            cnt   <= '0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    a     <= '0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Scoreboard bench for dec_scan_sequencer: expected channel/done events are
// queued from a list-based scan model and popped by an independent monitor.
module tb_dec_scan_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] mask;
    logic [7:0]  dwell;
    logic        continuous;
    logic [3:0]  a;
    logic        en;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       is_done;
        bit [3:0] ch;
    } exp_t;

    exp_t q[$];

    dec_scan_sequencer #(.DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mask(mask),
        .dwell(dwell), .continuous(continuous), .a(a), .en(en), .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected event list: every set bit ascending, each repeated max(d,1)
    // times; repeated when continuous; truncated to stop_after entries if a
    // stop is planned, otherwise a single pass ends with one done event.
    task automatic model_scan(input logic [15:0] m, input int d, input bit cont,
                              input int stop_after);
        int   deff;
        int   n;
        exp_t e;
        deff = (d == 0) ? 1 : d;
        n = 0;
        if (m == 16'h0) begin
            e.is_done = 1'b1; e.ch = 4'h0; q.push_back(e);
            return;
        end
        do begin
            for (int i = 0; i < 16; i++) begin
                if (m[i]) begin
                    for (int r = 0; r < deff; r++) begin
                        if (stop_after == 0 || n < stop_after) begin
                            e.is_done = 1'b0; e.ch = 4'(i); q.push_back(e);
                            n++;
                        end
                    end
                end
            end
        end while (cont && n < stop_after);
        if (stop_after == 0) begin
            e.is_done = 1'b1; e.ch = 4'h0; q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d expected events still pending, required 0", name, q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_scan(input string name, input logic [15:0] m, input int d,
                            input bit cont, input int stop_after, input bit scramble);
        model_scan(m, d, cont, stop_after);
        @(negedge clk); #1;
        start = 1'b1; stop = 1'b0; mask = m; dwell = 8'(d); continuous = cont;
        @(negedge clk); #1;
        start = 1'b0;
        if (scramble) begin
            start = 1'b1;
            mask = 16'($urandom); dwell = 8'($urandom_range(5, 9)); continuous = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
            mask = ~m; dwell = 8'd1;
        end
        if (stop_after > 0) begin
            repeat (stop_after - 1) @(negedge clk);
            #1 stop = 1'b1;
            @(negedge clk); #1;
            stop = 1'b0;
        end
        wait_drain(name);
    endtask

    // Monitor: compares each en/done cycle against the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (en) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL chan: en=1 a=%0d at %0t, required no activity", a, $time);
                    end else begin
                        if (q[0].is_done || q[0].ch != a) begin
                            errors++;
                            $display("FAIL chan: a=%0d en=1 at %0t, required %s%0d",
                                     a, $time, q[0].is_done ? "done, idx " : "a=", q[0].ch);
                        end
                        void'(q.pop_front());
                    end
                end
                if (done) begin
                    checks++;
                    if (q.size() == 0 || !q[0].is_done) begin
                        errors++;
                        $display("FAIL done: done=1 at %0t, required no done pulse", $time);
                    end
                    if (q.size() != 0) void'(q.pop_front());
                end
                checks++;
                if (busy != en || (!en && a != 4'h0) || (en && done)) begin
                    errors++;
                    $display("FAIL outs: a=%0d en=%0b busy=%0b done=%0b at %0t, required busy==en, a=0 when en=0",
                             a, en, busy, done, $time);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (a != 4'h0 || en || busy || done) begin
            errors++;
            $display("FAIL %s: a=%0d en=%0b busy=%0b done=%0b, required all 0", name, a, en, busy, done);
        end
    endtask

    initial begin
        logic [15:0] m;
        int          d;
        bit          c;
        int          total;
        int          sa;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mask = '0; dwell = '0; continuous = 1'b0;
        #2 check_zero("reset_state");
        #10 rst_n = 1'b1;

        run_scan("full_pass",   16'hFFFF, 1, 1'b0, 0, 1'b0);
        run_scan("sparse_dw3",  16'h8001, 3, 1'b0, 0, 1'b0);
        run_scan("cont_wrap",   16'h0006, 2, 1'b1, 11, 1'b0);
        run_scan("dwell_zero",  16'h0010, 0, 1'b0, 0, 1'b0);
        run_scan("mask_zero",   16'h0000, 3, 1'b0, 0, 1'b0);
        run_scan("capture",     16'h0421, 3, 1'b0, 0, 1'b1);
        run_scan("max_dwell",   16'h0100, 255, 1'b0, 0, 1'b0);

        // start together with stop must leave the sequencer idle
        @(negedge clk); #1;
        start = 1'b1; stop = 1'b1; mask = 16'hFFFF; dwell = 8'd1;
        @(negedge clk); #1;
        start = 1'b0; stop = 1'b0;
        check_zero("start_stop");
        wait_drain("start_stop");

        // asynchronous reset between edges in the middle of a scan
        model_scan(16'h00F0, 2, 1'b0, 0);
        @(negedge clk); #1;
        start = 1'b1; mask = 16'h00F0; dwell = 8'd2; continuous = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_zero("async_reset");
        q.delete();
        @(negedge clk); #1;
        check_zero("reset_hold");
        model_scan(16'h0300, 1, 1'b0, 0);
        rst_n = 1'b1;
        start = 1'b1; mask = 16'h0300; dwell = 8'd1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_drain("after_reset");

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 9) == 0)      m = 16'h0;
            else if ($urandom_range(0, 2) == 0) m = 16'h1 << $urandom_range(0, 15);
            else                                m = 16'($urandom);
            d = (it % 8 == 7) ? $urandom_range(5, 12) : $urandom_range(0, 4);
            total = $countones(m) * ((d == 0) ? 1 : d);
            c = 1'b0;
            sa = 0;
            if (m != 16'h0) begin
                c = 1'($urandom_range(0, 1));
                if (c)                                               sa = $urandom_range(1, 3 * total);
                else if ($urandom_range(0, 2) == 0 && total > 1)     sa = $urandom_range(1, total - 1);
            end
            run_scan("random", m, d, c, sa, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
